// File: rtl/multicycle_core.sv
// multicycle_core: multi-cycle 16-bit ISA core sharing one instruction/data memory port.
// Ports: clk, reset (sync, active-high);
//   mem_req/mem_we/mem_addr/mem_wdata drive the memory port, mem_rdata/mem_ready return from it;
//   pc_out is the address of the instruction in flight; halted/illegal report core status.
// Optional PERF_CNT_EN macro: adds saturating perf_cycles and perf_instret counters.
module multicycle_core #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int REG_CNT = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
`ifdef PERF_CNT_EN
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_instret,
`endif
    output logic              illegal
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_pc, r_npc;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_a, r_b, r_alu, r_mdr;
    // Eight slots always exist; slots at or above REG_CNT and slot 0 are never written, so they read 0.
    logic [DATA_W-1:0] r_regs [8];
    logic              r_illegal;
    logic [3:0]        w_op;
    logic [2:0]        w_rs, w_rt, w_rd, w_funct, w_dst;
    logic [DATA_W-1:0] w_imm, w_alu, w_wb_val;
    logic [ADDR_W-1:0] w_br_tgt, w_j_tgt, w_ea;
    logic              w_branch, w_mem_op, w_bad_op, w_taken, w_req, w_we;
    assign w_op     = r_ir[15:12];
    assign w_rs     = r_ir[11:9];
    assign w_rt     = r_ir[8:6];
    assign w_rd     = r_ir[5:3];
    assign w_funct  = r_ir[2:0];
    assign w_imm    = {{(DATA_W-6){r_ir[5]}}, r_ir[5:0]};
    assign w_br_tgt = r_npc + {{(ADDR_W-6){r_ir[5]}}, r_ir[5:0]};
    // Jump keeps the upper bits of PC+1 and replaces the low 12 bits.
    assign w_j_tgt  = (r_npc & ~ADDR_W'(12'hfff)) | ADDR_W'(r_ir[11:0]);
    assign w_ea     = ADDR_W'(r_alu);
    assign w_branch = w_op[3:2] == 2'b01;
    assign w_mem_op = w_op == 4'd2 || w_op == 4'd3;
    assign w_bad_op = w_op >= 4'd9 && w_op <= 4'd14;
    assign w_taken  = w_op == 4'd4 ? r_a == r_b :
                      w_op == 4'd5 ? r_a != r_b :
                      w_op == 4'd6 ? $signed(r_a) < $signed(r_b) :
                                     $signed(r_a) > $signed(r_b);
    assign w_alu    = w_op != 4'd0     ? r_a + w_imm :
                      w_funct == 3'd0  ? r_a + r_b :
                      w_funct == 3'd1  ? r_a - r_b :
                      w_funct == 3'd2  ? r_a & r_b :
                      w_funct == 3'd3  ? r_a | r_b :
                      w_funct == 3'd4  ? DATA_W'($signed(r_a) < $signed(r_b)) : '0;
    assign w_dst    = w_op == 4'd0 ? w_rd : w_rt;
    assign w_wb_val = w_op == 4'd2 ? r_mdr : r_alu;
    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        w_we   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req  = 1'b1;
                w_next = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: w_next = w_op == 4'd8 ? S_FETCH : (w_op == 4'd15 || w_bad_op) ? S_HALT : S_EXEC;
            S_EXEC:   w_next = w_branch ? S_FETCH : w_mem_op ? S_MEM : S_WB;
            S_MEM: begin
                w_req  = 1'b1;
                w_we   = w_op == 4'd3;
                w_next = !mem_ready ? S_MEM : w_op == 4'd2 ? S_WB : S_FETCH;
            end
            S_WB:     w_next = S_FETCH;
            default:  w_next = S_HALT;
        endcase
    end
    // Reset abandons an in-flight request in the same cycle it is asserted.
    assign mem_req   = w_req && !reset;
    assign mem_we    = w_we && !reset;
    assign mem_addr  = reset ? '0 : r_state == S_MEM ? w_ea : r_pc;
    assign mem_wdata = (w_we && !reset) ? r_b : '0;
    assign pc_out    = r_pc;
    assign halted    = r_state == S_HALT;
    assign illegal   = r_illegal;
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= '0;
            r_npc     <= '0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_illegal <= 1'b0;
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: if (mem_ready) begin
                    r_ir  <= mem_rdata[15:0];
                    r_npc <= r_pc + 1'b1;
                end
                S_DECODE: begin
                    r_a <= r_regs[w_rs];
                    r_b <= r_regs[w_rt];
                    if (w_op == 4'd8) r_pc <= w_j_tgt;
                    if (w_bad_op) r_illegal <= 1'b1;
                end
                S_EXEC: begin
                    r_alu <= w_alu;
                    if (w_branch) r_pc <= w_taken ? w_br_tgt : r_npc;
                end
                S_MEM: if (mem_ready) begin
                    if (w_op == 4'd2) r_mdr <= mem_rdata;
                    else              r_pc  <= r_npc;
                end
                S_WB: begin
                    if (w_dst != 3'd0 && int'(w_dst) < REG_CNT) r_regs[w_dst] <= w_wb_val;
                    r_pc <= r_npc;
                end
                default: ;
            endcase
        end
    end
`ifdef PERF_CNT_EN
    logic [31:0] r_cycles, r_instret;
    logic        w_retire;
    assign w_retire = r_state == S_WB
                   || (r_state == S_MEM && mem_ready && w_op == 4'd3)
                   || (r_state == S_EXEC && w_branch)
                   || (r_state == S_DECODE && (w_op == 4'd8 || w_op == 4'd15));
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycles  <= '0;
            r_instret <= '0;
        end else begin
            if (r_state != S_HALT && !(&r_cycles)) r_cycles <= r_cycles + 32'd1;
            if (w_retire && !(&r_instret)) r_instret <= r_instret + 32'd1;
        end
    end
    assign perf_cycles  = r_cycles;
    assign perf_instret = r_instret;
`endif
endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed programs for multicycle_core with a 256-word memory model.
module tb_multicycle_core;
    logic        clk = 1'b0, reset = 1'b1, mem_ready = 1'b1, ld_en = 1'b0;
    logic        mem_req, mem_we, halted, illegal;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, pc_out;
`ifdef PERF_CNT_EN
    logic [31:0] perf_cycles, perf_instret;
`endif
    logic [15:0] mem [256];
    logic [15:0] img [256];
    logic [15:0] fq [$];
    logic [15:0] wr_addr, wr_data;
    int          wr_cnt, hcyc;
    int          npass = 0, nfail = 0, nchk = 0;

    multicycle_core dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_out(pc_out), .halted(halted),
`ifdef PERF_CNT_EN
        .perf_cycles(perf_cycles), .perf_instret(perf_instret),
`endif
        .illegal(illegal)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr[7:0]];

    always @(posedge clk) begin
        if (ld_en) begin
            mem    <= img;
            wr_cnt <= 0;
            fq.delete();
        end else if (mem_req && mem_ready) begin
            if (mem_we) begin
                mem[mem_addr[7:0]] <= mem_wdata;
                wr_cnt  <= wr_cnt + 1;
                wr_addr <= mem_addr;
                wr_data <= mem_wdata;
            end else fq.push_back(mem_addr);
        end
    end

    // Cycles spent not halted since reset release: the program's total latency.
    always @(posedge clk) begin
        if (reset)        hcyc <= 0;
        else if (!halted) hcyc <= hcyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic rdy);
        reset = 1'b1;
        mem_ready = rdy;
        ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_halt(input string tag);
        int n = 0;
        while (!halted && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, halted, 1);
    endtask

    initial begin
        int n;
        // addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; halt
        img = '{default: '0};
        img[0] = 16'h1045; img[1] = 16'h10BD; img[2] = 16'h0298; img[3] = 16'hF000;
        load(1'b1);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        reset = 1'b0;
        #1;
        chk("first_fetch_req", mem_req, 1);
        wait_halt("p1_halt");
        chk("p1_r3", dut.r_regs[3], 16'h0002);
        chk("p1_cycles", hcyc, 14);
        chk("p1_pc", pc_out, 3);
        chk("p1_req_off", mem_req, 0);
        chk("p1_illegal", illegal, 0);
`ifdef PERF_CNT_EN
        chk("p1_perf_instret", perf_instret, 4);
        chk("p1_perf_cycles", perf_cycles, 14);
`endif
        repeat (5) @(negedge clk);
        chk("p1_stay_halted", hcyc, 14);
        chk("p1_req_still_off", mem_req, 0);
`ifdef PERF_CNT_EN
        chk("p1_perf_cycles_frozen", perf_cycles, 14);
        chk("p1_perf_instret_frozen", perf_instret, 4);
`endif

        // j 16; lw r1,20(r0); sw r1,2(r0); lw r4,2(r0); halt; M[20]=0x00A5
        img = '{default: '0};
        img[0] = 16'h8010; img[16] = 16'h2054; img[17] = 16'h3042;
        img[18] = 16'h2102; img[19] = 16'hF000; img[20] = 16'h00A5;
        load(1'b1);
        reset = 1'b0;
        wait_halt("p2_halt");
        chk("p2_write_count", wr_cnt, 1);
        chk("p2_write_addr", wr_addr, 16'h0002);
        chk("p2_write_data", wr_data, 16'h00A5);
        chk("p2_mem2", mem[2], 16'h00A5);
        chk("p2_r1", dut.r_regs[1], 16'h00A5);
        chk("p2_r4", dut.r_regs[4], 16'h00A5);
        chk("p2_cycles", hcyc, 18);
        chk("p2_pc", pc_out, 19);

        // addi r1,5; addi r2,-3; blt r2,r1,+2 (taken); addi r5,1; halt; bgt r2,r1,+2 (not); addi r6,7; halt
        img = '{default: '0};
        img[0] = 16'h1045; img[1] = 16'h10BD; img[2] = 16'h6442; img[3] = 16'h1141;
        img[4] = 16'hF000; img[5] = 16'h7442; img[6] = 16'h1187; img[7] = 16'hF000;
        load(1'b1);
        reset = 1'b0;
        wait_halt("p3_halt");
        chk("p3_fetch_count", fq.size(), 6);
        chk("p3_blt_target", fq.size() > 3 ? fq[3] : 16'hFFFF, 16'h0005);
        chk("p3_bgt_fallthru", fq.size() > 4 ? fq[4] : 16'hFFFF, 16'h0006);
        chk("p3_r5_skipped", dut.r_regs[5], 16'h0000);
        chk("p3_r6", dut.r_regs[6], 16'h0007);
        chk("p3_cycles", hcyc, 20);
        chk("p3_pc", pc_out, 7);

        // addi r1,r0,9; sw r1,30(r0); halt -- with 3-cycle stalls in FETCH and MEM
        img = '{default: '0};
        img[0] = 16'h1049; img[1] = 16'h305E; img[2] = 16'hF000;
        load(1'b0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("fstall_req", mem_req, 1);
            chk("fstall_addr", mem_addr, 0);
            chk("fstall_we", mem_we, 0);
            chk("fstall_pc", pc_out, 0);
        end
        mem_ready = 1'b1;
        n = 0;
        while (!(mem_req && mem_we) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("sw_req_seen", mem_we, 1);
        mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mstall_req", mem_req, 1);
            chk("mstall_addr", mem_addr, 16'h001E);
            chk("mstall_we", mem_we, 1);
            chk("mstall_wdata", mem_wdata, 16'h0009);
        end
        mem_ready = 1'b1;
        wait_halt("p4_halt");
        chk("p4_cycles", hcyc, 16);
        chk("p4_mem30", mem[30], 16'h0009);
        chk("p4_write_count", wr_cnt, 1);

        // j 7; opcode 0xA at address 7
        img = '{default: '0};
        img[0] = 16'h8007; img[7] = 16'hA000;
        load(1'b1);
        reset = 1'b0;
        wait_halt("p5_halt");
        chk("p5_illegal", illegal, 1);
        chk("p5_req_off", mem_req, 0);
        chk("p5_pc", pc_out, 7);
        chk("p5_cycles", hcyc, 4);
        repeat (3) @(negedge clk);
        chk("p5_req_still_off", mem_req, 0);
        chk("p5_illegal_sticky", illegal, 1);

        // reset asserted while a fetch is stalled
        img = '{default: '0};
        img[0] = 16'h1045; img[1] = 16'h10BD; img[2] = 16'h0298; img[3] = 16'hF000;
        load(1'b1);
        reset = 1'b0;
        n = 0;
        while (pc_out != 16'd1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("p6_pc_reached", pc_out, 1);
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("p6_stall_req", mem_req, 1);
        chk("p6_stall_addr", mem_addr, 1);
        chk("p6_r1_before", dut.r_regs[1], 16'h0005);
        reset = 1'b1;
        @(negedge clk);
        chk("p6_rst_req", mem_req, 0);
        chk("p6_rst_pc", pc_out, 0);
        chk("p6_rst_r1", dut.r_regs[1], 16'h0000);
        chk("p6_rst_addr", mem_addr, 0);
        chk("p6_rst_halted", halted, 0);
        chk("p6_rst_illegal", illegal, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised multi-cycle successor to the team's 16-bit single-cycle processor.
- Executes the same 16-bit ISA family, one instruction per several cycles, through a single shared instruction/data memory port with a req/ready handshake.
- Data width, address width and register count are parametrised.
- Sits between the testbench/SoC memory model and the debug/status logic; the existing single-cycle datapath submodules are not reused.

Parameters:
- DATA_W, 16, register/ALU/data width; must be >= 16; instruction = mem_rdata[15:0].
- ADDR_W, 16, word address width; must be >= 12.
- REG_CNT, 8, number of architectural registers; must be <= 8 (3-bit specifiers); r0 reads zero, writes ignored.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- mem_req  output  1  memory transaction request
- mem_we  output  1  1 = write, 0 = read
- mem_addr  output  ADDR_W  word address
- mem_wdata  output  DATA_W  store data
- mem_rdata  input  DATA_W  read data; valid in the cycle mem_req & mem_ready
- mem_ready  input  1  transaction completes in the cycle mem_req & mem_ready
- pc_out  output  ADDR_W  address of the current instruction
- halted  output  1  core stopped (HALT or illegal opcode)
- illegal  output  1  sticky; set on an undefined opcode

Behaviour:
- Reset is synchronous, active-high, and has priority over everything, including mid-handshake: the request is abandoned.
  - Reset values: PC = 0, state = FETCH, all registers = 0, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, halted = 0, illegal = 0.
- Instruction encoding:
  - op[15:12], rs[11:9], rt[8:6], rd[5:3], funct[2:0], imm6[5:0] (sign-extended), imm12[11:0].
- Opcodes:
  - 0 R-type: funct 0 add, 1 sub, 2 and, 3 or, 4 slt (signed; result 1/0). Other funct values write 0. Destination rd.
  - 1 addi: rt = rs + sext(imm6).
  - 2 lw: rt = M[rs + sext(imm6)].
  - 3 sw: M[rs + sext(imm6)] = rt.
  - 4 beq, 5 bne, 6 blt (signed rs<rt), 7 bgt (signed rs>rt); taken target = PC + 1 + sext(imm6).
  - 8 j: PC = {(PC+1)[ADDR_W-1:12], imm12}.
  - 15 halt.
  - 9 to 14: illegal.
- Arithmetic wraps modulo 2^DATA_W. Effective address = low ADDR_W bits of the sum. Register specifiers >= REG_CNT read 0 and are not written.
- States:
  - FETCH: mem_req = 1, mem_we = 0, mem_addr = PC. On ready: latch IR, latch PC+1 → DECODE.
  - DECODE: read rs/rt into A/B.
    - j: PC = target → FETCH.
    - halt: → HALT.
    - illegal opcode: set illegal → HALT.
    - otherwise: → EXEC.
  - EXEC: ALU or address compute.
    - Branch: PC = taken ? target : PC+1 → FETCH.
    - lw/sw: → MEM.
    - R/addi: → WB.
  - MEM: mem_req = 1, mem_we = (sw), mem_addr = ALUOut, mem_wdata = B. On ready: lw latches MDR → WB; sw sets PC = PC+1 → FETCH.
  - WB: write the result (rd for R-type, rt otherwise), PC = PC+1 → FETCH.
  - HALT: mem_req = 0; halted = 1; stays until reset.
- Handshake:
  - While mem_req = 1 and mem_ready = 0, addr/we/wdata are held stable and the state does not advance.
  - mem_req deasserts in the cycle after completion unless the next state also requests (e.g. a non-FETCH state returning to FETCH keeps mem_req high).
  - mem_ready is ignored while mem_req = 0.
- Latency with zero-wait memory (ready tied 1): R/addi 4, lw 5, sw 4, branch 3, j 2 cycles. Each wait cycle adds 1.
- PC wraps at 2^ADDR_W.
- pc_out = PC of the instruction in flight; it updates when the next FETCH begins.

Optional Feature:
- PERF_CNT_EN: adds outputs perf_cycles[31:0] and perf_instret[31:0].
  - perf_cycles counts every non-reset cycle while halted = 0.
  - perf_instret increments once per retired instruction: WB, sw completion, branch/j resolution, or halt in DECODE.
  - Both clear on reset and saturate at all-ones.
  - Without the macro these ports and the counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then ready = 1; program "addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; halt" → r3 = 2, halted = 1 after 4+4+4+2 = 14 fetch-to-halt cycles, pc_out = 3.
- sw r1,2(r0) with r1 = 0x00A5, then lw r4,2(r0) → write request addr = 2, wdata = 0x00A5, we = 1; r4 = 0x00A5. Load takes 5 cycles with ready = 1.
- blt r2,r1,+2 with r2 = -3, r1 = 5 → taken, next fetch address = PC+3. bgt with the same operands → not taken, next fetch address = PC+1.
- mem_ready held low 3 cycles during FETCH and MEM → mem_addr/mem_we/mem_wdata stable throughout, state frozen, instruction latency +3 each.
- Opcode 0xA at address 7 → illegal = 1, halted = 1, mem_req = 0 thereafter. Assert reset mid-stall (mem_req = 1, ready = 0) → next cycle mem_req = 0, pc_out = 0, registers 0.
- PERF_CNT_EN defined: first program above → perf_instret = 4, perf_cycles = 14; counters stop after halt.
